// File: rtl/apb_req_arbiter.sv
// Two-port request arbiter in front of the APB master's internal request
// interface. Each port owns a one-deep request buffer; the FSM grants one
// buffered request at a time, issues a single master strobe, waits for
// completion and returns read data plus a done pulse to the granted port.
module apb_req_arbiter #(
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  // port 0 (CPU load/store)
  input  logic              s0_transfer,
  input  logic              s0_write,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_wdata,
  output logic              s0_busy,
  output logic              s0_ready,
  output logic [DATA_W-1:0] s0_rdata,
  // port 1 (DMA / debug)
  input  logic              s1_transfer,
  input  logic              s1_write,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_wdata,
  output logic              s1_busy,
  output logic              s1_ready,
  output logic [DATA_W-1:0] s1_rdata,
  // APB master request interface
  output logic              m_transfer,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                   state_q, state_d;
  logic                     grant_q, grant_d;
  logic                     last_grant_q, last_grant_d;
  logic [1:0]               busy_q, busy_d;
  logic [1:0]               cap;
  logic [1:0]               done;
  logic                     xfer_done;
  logic                     drive;
  logic [1:0]               wr_q;
  logic [1:0][ADDR_W-1:0]   addr_q;
  logic [1:0][DATA_W-1:0]   wdata_q;
  logic [1:0][DATA_W-1:0]   rdata_q;

  // A strobe is only accepted into an empty buffer; strobes on a busy port are dropped.
  assign cap       = {s1_transfer & ~busy_q[1], s0_transfer & ~busy_q[0]};
  assign xfer_done = (state_q == ST_WAIT) && m_ready;
  assign done      = {xfer_done & grant_q, xfer_done & ~grant_q};

  // Buffer occupancy: released when the granted transfer completes, set on capture.
  always_comb begin
    busy_d = (busy_q & ~done) | cap;
  end

  // Request buffers: contents only change on capture into an empty buffer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      busy_q  <= '0;
      wr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      busy_q <= busy_d;
      if (cap[0]) begin
        wr_q[0]    <= s0_write;
        addr_q[0]  <= s0_addr;
        wdata_q[0] <= s0_wdata;
      end
      if (cap[1]) begin
        wr_q[1]    <= s1_write;
        addr_q[1]  <= s1_addr;
        wdata_q[1] <= s1_wdata;
      end
    end
  end

  // Arbitration and transfer sequencing.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (busy_q != 2'b00) begin
          state_d = ST_ISSUE;
          if (busy_q == 2'b11) begin
            grant_d = (PRIORITY_MODE == 1) ? 1'b0 : ~last_grant_q;
          end else begin
            grant_d = busy_q[1];
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (m_ready) begin
          last_grant_d = grant_q;
          state_d      = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM registers; last_grant resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Per-port read data, held until that port's next completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rdata_q <= '0;
    end else begin
      if (done[0]) rdata_q[0] <= m_rdata;
      if (done[1]) rdata_q[1] <= m_rdata;
    end
  end

  assign drive      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign m_transfer = (state_q == ST_ISSUE);
  assign m_write    = drive & wr_q[grant_q];
  assign m_addr     = drive ? addr_q[grant_q]  : '0;
  assign m_wdata    = drive ? wdata_q[grant_q] : '0;

  assign s0_busy  = busy_q[0];
  assign s1_busy  = busy_q[1];
  assign s0_ready = (state_q == ST_RESP) && !grant_q;
  assign s1_ready = (state_q == ST_RESP) &&  grant_q;
  assign s0_rdata = rdata_q[0];
  assign s1_rdata = rdata_q[1];

endmodule
